stream_mux_rr: RTL and testbench
================================

Name: stream_mux_rr

Overview:
- Parametrised N-channel, WIDTH-bit multiplexer. Successor to the fixed 8:1 16-bit combinational mux family.
- Adds per-channel valid/ready handshakes, a registered output stage and two selection modes:
  - fixed select, steered by `sel`;
  - round-robin arbitration across all requesting channels.
- Sits between multiple producer blocks and a single shared consumer (datapath bus or ALU operand port).

Parameters:
- NCH, 8, number of input channels; 2..16.
- WIDTH, 16, data width per channel in bits.
- SELW, 3, width of `sel`/`out_ch`; must satisfy 2**SELW >= NCH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  NCH*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NCH  per-channel request; bit i belongs to channel i.
- in_ready  output  NCH  per-channel accept; combinational.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SELW  channel index used when mode = 0.
- out_data  output  WIDTH  registered output data.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  consumer accepts the word this cycle.
- out_ch  output  SELW  index of the channel that supplied out_data.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid = 0, out_data = 0, out_ch = 0, round-robin pointer ptr = 0.
  - in_ready is all-zero while rst_n is low.
  - Reset asserted mid-transfer discards the held word; no handshake completes in that cycle.
- Load condition: load = !out_valid || out_ready. The output register accepts a new word when it is empty or is being drained in the same cycle, so a continuous stream sustains full throughput.
- Channel choice, computed combinationally each cycle:
  - mode = 0: chosen = sel; request = in_valid[sel]. If sel >= NCH, there is no request.
  - mode = 1: chosen = first i with in_valid[i] = 1, scanning ptr, ptr+1, ... NCH-1, 0, ... ptr-1. There is no request if in_valid = 0.
- in_ready[i] = load && request && (i == chosen). At most one bit is set. All other bits are 0.
- Input transfer occurs on a clock edge with in_valid[i] && in_ready[i]. On that edge:
  - out_data <= channel-i data, out_ch <= i, out_valid <= 1.
  - If mode = 1: ptr <= (i+1) mod NCH, wrapping NCH-1 -> 0.
- If load is true and there is no request: out_valid <= 0. out_data and out_ch hold their last values.
- If load is false (out_valid=1, out_ready=0): out_data, out_ch and out_valid hold. All in_ready bits are 0.
- Latency: 1 cycle from input transfer to out_valid.
- Simultaneous drain and load: the old word leaves and the new word enters on the same edge; out_valid stays 1.
- ptr is updated only by round-robin transfers. Fixed-mode transfers leave it unchanged.
- Changes to mode or sel take effect in the same cycle's combinational choice. They never disturb a word already held in the output register.
- Fairness: in mode 1 with all channels continuously valid and out_ready = 1, grants cycle 0,1,...,NCH-1,0,... with no channel skipped.
- Data is passed unmodified. No width conversion; no arithmetic beyond the modulo-NCH pointer increment.

Test Plan:
- Reset mid-stream: rst_n low while out_valid=1, out_data=16'hBEEF -> out_valid=0, out_data=0, out_ch=0, in_ready=0 immediately, without waiting for a clock edge.
- Fixed mode, sel=5, channel 5 data=16'h1234, in_valid=8'hFF, out_ready=1 -> in_ready=8'h20; next cycle out_data=16'h1234, out_ch=5. Then sel=9 with SELW=4, NCH=8 -> in_ready=0 and out_valid drops.
- Round-robin, all 8 channels valid, channel i data = 16'h00i0, out_ready=1 for 10 cycles -> out_ch sequence 0,1,...,7,0,1; out_valid stays 1 throughout.
- Round-robin sparse requests: in_valid=8'b1000_0100 with ptr=3 -> channel 2 granted only after channel 7; the next grant is channel 2 and ptr wraps to 3.
- Backpressure: out_valid=1, out_ready=0 for 4 cycles with all inputs valid -> in_ready=0, out_data stable. Release out_ready -> the held word drains and a new word loads on the same edge.
- Mode switch: mode 1 -> 0 while ptr=6, sel=1 -> channel 1 is granted. Return to mode 1 -> arbitration resumes from ptr=6.

Source files
------------

// File: rtl/stream_mux_rr_if.sv
// -----------------------------------------------------------------------------
// stream_mux_rr_if
// Bundles the streaming handshake signals of stream_mux_rr.
//   in_data   : NCH*WIDTH packed producer data, channel i at [i*WIDTH +: WIDTH]
//   in_valid  : per-channel request from the producers
//   in_ready  : per-channel accept back to the producers (combinational)
//   out_data  : registered word presented to the consumer
//   out_valid : output register holds a word
//   out_ready : consumer accepts the word this cycle
//   out_ch    : index of the channel that supplied out_data
// Modports:
//   slave  - the multiplexer itself
//   master - the environment (producers plus consumer)
// -----------------------------------------------------------------------------
interface stream_mux_rr_if #(
    parameter int NCH   = 8,
    parameter int WIDTH = 16,
    parameter int SELW  = 3
) ();
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic [WIDTH-1:0]     out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [SELW-1:0]      out_ch;

    modport slave (
        input  in_data,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_data,
        output out_valid,
        output out_ch
    );

    modport master (
        output in_data,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_data,
        input  out_valid,
        input  out_ch
    );
endinterface

// File: rtl/stream_mux_rr.sv
// -----------------------------------------------------------------------------
// stream_mux_rr
// N-channel, WIDTH-bit stream multiplexer with a registered output stage.
// mode = 0 steers channel `sel` to the output; mode = 1 arbitrates round-robin
// across all requesting channels, starting the scan at the pointer that sits
// one past the last round-robin winner.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   mode  : 0 = fixed select, 1 = round-robin
//   sel   : channel index used in fixed mode (values >= NCH request nothing)
//   bus   : handshake bundle (see stream_mux_rr_if), slave side
// -----------------------------------------------------------------------------
module stream_mux_rr #(
    parameter int NCH   = 8,
    parameter int WIDTH = 16,
    parameter int SELW  = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mode,
    input  logic [SELW-1:0] sel,
    stream_mux_rr_if.slave  bus
);

    logic                 r_out_valid;
    logic [WIDTH-1:0]     r_out_data;
    logic [SELW-1:0]      r_out_ch;
    logic [SELW-1:0]      r_ptr;

    logic                 w_load;
    logic                 w_fix_req;
    logic                 w_rr_req;
    logic [SELW-1:0]      w_rr_ch;
    logic                 w_req;
    logic [SELW-1:0]      w_chosen;
    logic [SELW-1:0]      w_ptr_next;
    logic [WIDTH-1:0]     w_data;
    logic [NCH-1:0]       w_in_ready;

    // The output register can take a word when empty or draining this cycle.
    assign w_load = !r_out_valid || bus.out_ready;

    // Fixed-select request: a sel value with no matching channel yields none.
    always_comb begin
        w_fix_req = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            w_fix_req = w_fix_req | ((sel == SELW'(i)) & bus.in_valid[i]);
        end
    end

    // Round-robin scan: first pass covers ptr..NCH-1, second pass 0..ptr-1.
    always_comb begin : rr_scan
        logic hit;
        hit      = 1'b0;
        w_rr_req = 1'b0;
        w_rr_ch  = {SELW{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            hit      = bus.in_valid[i] && (SELW'(i) >= r_ptr) && !w_rr_req;
            w_rr_ch  = hit ? SELW'(i) : w_rr_ch;
            w_rr_req = w_rr_req | hit;
        end
        for (int i = 0; i < NCH; i++) begin
            hit      = bus.in_valid[i] && (SELW'(i) < r_ptr) && !w_rr_req;
            w_rr_ch  = hit ? SELW'(i) : w_rr_ch;
            w_rr_req = w_rr_req | hit;
        end
    end

    // Mode steering of the request and the chosen channel.
    assign w_req    = mode ? w_rr_req : w_fix_req;
    assign w_chosen = mode ? w_rr_ch  : sel;

    // Pointer moves one past the winner, wrapping NCH-1 back to 0.
    assign w_ptr_next = (w_chosen == SELW'(NCH - 1)) ? {SELW{1'b0}}
                                                     : (w_chosen + {{(SELW-1){1'b0}}, 1'b1});

    // One-hot accept; held low throughout reset so nothing completes then.
    always_comb begin
        w_in_ready = {NCH{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            w_in_ready[i] = rst_n & w_load & w_req & (w_chosen == SELW'(i));
        end
    end

    // Data select of the chosen channel.
    always_comb begin
        w_data = {WIDTH{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            w_data = (w_chosen == SELW'(i)) ? bus.in_data[i*WIDTH +: WIDTH] : w_data;
        end
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= {WIDTH{1'b0}};
            r_out_ch    <= {SELW{1'b0}};
            r_ptr       <= {SELW{1'b0}};
        end else if (w_load) begin
            if (w_req) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_data;
                r_out_ch    <= w_chosen;
                if (mode) begin
                    r_ptr <= w_ptr_next;
                end else begin
                    r_ptr <= r_ptr;
                end
            end else begin
                // Empty after drain; data and channel keep their last values.
                r_out_valid <= 1'b0;
            end
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_ch    = r_out_ch;

endmodule

// File: tb/tb_stream_mux_rr.sv
// -----------------------------------------------------------------------------
// tb_stream_mux_rr
// Self-checking bench for stream_mux_rr (NCH=8, WIDTH=16, SELW=4). A reference
// model predicts in_ready each cycle and pushes every expected transfer onto a
// scoreboard queue; the head of the queue is compared against the output
// register after each clock edge.
// -----------------------------------------------------------------------------
module tb_stream_mux_rr;
    localparam int NCH   = 8;
    localparam int WIDTH = 16;
    localparam int SELW  = 4;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic [SELW-1:0]  c;
    } exp_t;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic            mode  = 1'b0;
    logic [SELW-1:0] sel   = 4'd0;
    logic [WIDTH-1:0] ch_data [NCH];

    int   checks   = 0;
    int   failures = 0;
    bit   m_valid  = 1'b0;
    int   m_ptr    = 0;
    exp_t sb [$];

    stream_mux_rr_if #(.NCH(NCH), .WIDTH(WIDTH), .SELW(SELW)) mif ();

    stream_mux_rr #(.NCH(NCH), .WIDTH(WIDTH), .SELW(SELW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mode  (mode),
        .sel   (sel),
        .bus   (mif)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            mif.in_data[i*WIDTH +: WIDTH] = ch_data[i];
        end
    end

    // One clock of the reference model: predict grant, advance, check output.
    task automatic cycle(input string tag);
        logic [NCH-1:0] exp_rdy;
        bit   req, load, drained, cur_mode;
        int   ch;
        exp_t e;
        load = !m_valid || mif.out_ready;
        req  = 1'b0;
        ch   = 0;
        cur_mode = mode;
        if (mode == 1'b0) begin
            if (int'(sel) < NCH) begin
                ch  = int'(sel);
                req = mif.in_valid[ch];
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
                int idx;
                idx = (m_ptr + k) % NCH;
                if (!req && mif.in_valid[idx]) begin
                    req = 1'b1;
                    ch  = idx;
                end
            end
        end
        exp_rdy = (load && req) ? (NCH'(1) << ch) : {NCH{1'b0}};
        checks++;
        if (mif.in_ready !== exp_rdy) begin
            failures++;
            $display("FAIL %s in_ready: got %h want %h", tag, mif.in_ready, exp_rdy);
        end
        drained = m_valid && mif.out_ready;
        e.d = ch_data[ch];
        e.c = SELW'(ch);
        @(posedge clk);
        #1;
        if (drained && sb.size() > 0) void'(sb.pop_front());
        if (load) begin
            if (req) begin
                sb.push_back(e);
                m_valid = 1'b1;
                if (cur_mode) m_ptr = (ch + 1) % NCH;
            end else begin
                m_valid = 1'b0;
            end
        end
        checks++;
        if (mif.out_valid !== m_valid) begin
            failures++;
            $display("FAIL %s out_valid: got %b want %b", tag, mif.out_valid, m_valid);
        end
        if (m_valid && sb.size() > 0) begin
            checks++;
            if (mif.out_data !== sb[0].d || mif.out_ch !== sb[0].c) begin
                failures++;
                $display("FAIL %s out_word: got %h/ch%0d want %h/ch%0d",
                         tag, mif.out_data, mif.out_ch, sb[0].d, sb[0].c);
            end
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (mif.out_valid !== 1'b0 || mif.out_data !== 16'h0000 ||
            mif.out_ch !== 4'd0 || mif.in_ready !== 8'h00) begin
            failures++;
            $display("FAIL reset_state: got v=%b d=%h c=%0d r=%h want 0/0000/0/00",
                     mif.out_valid, mif.out_data, mif.out_ch, mif.in_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_fixed();
        for (int i = 0; i < NCH; i++) ch_data[i] = 16'h1000 + 16'(i);
        ch_data[5]    = 16'h1234;
        mode          = 1'b0;
        sel           = 4'd5;
        mif.in_valid  = 8'hFF;
        mif.out_ready = 1'b1;
        #1;
        checks++;
        if (mif.in_ready !== 8'h20) begin
            failures++;
            $display("FAIL fixed_ready: got %h want 20", mif.in_ready);
        end
        cycle("fixed_sel5");
        checks++;
        if (mif.out_data !== 16'h1234 || mif.out_ch !== 4'd5) begin
            failures++;
            $display("FAIL fixed_out: got %h/ch%0d want 1234/ch5", mif.out_data, mif.out_ch);
        end
        sel = 4'd9;
        #1;
        checks++;
        if (mif.in_ready !== 8'h00) begin
            failures++;
            $display("FAIL sel_oob_ready: got %h want 00", mif.in_ready);
        end
        cycle("fixed_sel9");
        checks++;
        if (mif.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL sel_oob_valid: got %b want 0", mif.out_valid);
        end
    endtask

    task automatic test_rr_fair();
        for (int i = 0; i < NCH; i++) ch_data[i] = 16'(i) << 4;
        mode          = 1'b1;
        mif.in_valid  = 8'hFF;
        mif.out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #1;
            cycle("rr_fair");
            checks++;
            if (mif.out_valid !== 1'b1 || mif.out_ch !== 4'(k % NCH) ||
                mif.out_data !== (16'(k % NCH) << 4)) begin
                failures++;
                $display("FAIL rr_seq[%0d]: got v=%b ch%0d d=%h want 1/ch%0d",
                         k, mif.out_valid, mif.out_ch, mif.out_data, k % NCH);
            end
        end
    endtask

    task automatic test_rr_sparse();
        logic [SELW-1:0] want [4];
        logic [NCH-1:0]  reqs [4];
        reqs[0] = 8'b0000_0100; want[0] = 4'd2;
        reqs[1] = 8'b1000_0100; want[1] = 4'd7;
        reqs[2] = 8'b1000_0100; want[2] = 4'd2;
        reqs[3] = 8'b0000_1100; want[3] = 4'd3;
        mode = 1'b1;
        for (int k = 0; k < 4; k++) begin
            mif.in_valid = reqs[k];
            #1;
            cycle("rr_sparse");
            checks++;
            if (mif.out_ch !== want[k]) begin
                failures++;
                $display("FAIL rr_sparse[%0d]: got ch%0d want ch%0d", k, mif.out_ch, want[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        mode          = 1'b1;
        mif.in_valid  = 8'hFF;
        mif.out_ready = 1'b1;
        #1;
        cycle("bp_load");
        mif.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (mif.in_ready !== 8'h00) begin
                failures++;
                $display("FAIL bp_ready[%0d]: got %h want 00", k, mif.in_ready);
            end
            cycle("bp_hold");
            checks++;
            if (mif.out_data !== 16'h0040 || mif.out_ch !== 4'd4) begin
                failures++;
                $display("FAIL bp_stable[%0d]: got %h/ch%0d want 0040/ch4", k, mif.out_data, mif.out_ch);
            end
        end
        mif.out_ready = 1'b1;
        #1;
        cycle("bp_release");
        checks++;
        if (mif.out_valid !== 1'b1 || mif.out_ch !== 4'd5 || mif.out_data !== 16'h0050) begin
            failures++;
            $display("FAIL bp_release: got v=%b %h/ch%0d want 1 0050/ch5",
                     mif.out_valid, mif.out_data, mif.out_ch);
        end
    endtask

    task automatic test_mode_switch();
        mode = 1'b0;
        sel  = 4'd1;
        #1;
        checks++;
        if (mif.in_ready !== 8'h02) begin
            failures++;
            $display("FAIL mode_fixed_ready: got %h want 02", mif.in_ready);
        end
        cycle("mode_fixed");
        checks++;
        if (mif.out_ch !== 4'd1) begin
            failures++;
            $display("FAIL mode_fixed_ch: got ch%0d want ch1", mif.out_ch);
        end
        mode = 1'b1;
        #1;
        cycle("mode_rr");
        checks++;
        if (mif.out_ch !== 4'd6) begin
            failures++;
            $display("FAIL mode_rr_resume: got ch%0d want ch6", mif.out_ch);
        end
    endtask

    task automatic test_reset_midstream();
        ch_data[0]    = 16'hBEEF;
        mode          = 1'b0;
        sel           = 4'd0;
        mif.in_valid  = 8'hFF;
        mif.out_ready = 1'b1;
        #1;
        cycle("rst_load");
        mif.out_ready = 1'b0;
        #1;
        cycle("rst_hold");
        checks++;
        if (mif.out_data !== 16'hBEEF || mif.out_valid !== 1'b1) begin
            failures++;
            $display("FAIL rst_pre: got v=%b %h want 1 BEEF", mif.out_valid, mif.out_data);
        end
        mif.out_ready = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (mif.out_valid !== 1'b0 || mif.out_data !== 16'h0000 ||
            mif.out_ch !== 4'd0 || mif.in_ready !== 8'h00) begin
            failures++;
            $display("FAIL rst_async: got v=%b d=%h c=%0d r=%h want 0/0000/0/00",
                     mif.out_valid, mif.out_data, mif.out_ch, mif.in_ready);
        end
        m_valid = 1'b0;
        m_ptr   = 0;
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mode  = 1'b1;
        #1;
        cycle("rst_after");
        checks++;
        if (mif.out_ch !== 4'd0) begin
            failures++;
            $display("FAIL rst_ptr: got ch%0d want ch0", mif.out_ch);
        end
    endtask

    initial begin
        for (int i = 0; i < NCH; i++) ch_data[i] = 16'h0000;
        mif.in_valid  = 8'h00;
        mif.out_ready = 1'b0;
        test_reset();
        test_fixed();
        test_rr_fair();
        test_rr_sparse();
        test_backpressure();
        test_mode_switch();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
